lsu_mem: RTL and testbench
==========================

# lsu_mem

Load/store unit in the MEM stage of the RISC-V core. It takes the effective address the EXE-stage ALU computed for loads and stores, drives a request/ready handshake to data memory with byte strobes, and returns sign- or zero-extended load data to writeback. It stalls the pipeline while an access is outstanding and flags misaligned accesses.

## Interface
- `data_size`, 32: datapath width, taken from `define.sv`; the block supports only 32.
- `clk` input 1: core clock.
- `rst_n` input 1: synchronous, active-low reset.
- `valid_MEM` input 1: the MEM-stage instruction is valid.
- `opcode_MEM` input 7: `7'b0000011` is a load, `Stype` is a store, any other value is ignored.
- `funct3_MEM` input 3: access size and sign, using RISC-V encoding (LB/LH/LW/LBU/LHU, SB/SH/SW).
- `addr` input 32: effective address, the ALU result.
- `store_data` input 32: rs2 value, unaligned LSBs.
- `dm_req` output 1: memory request.
- `dm_we` output 1: 1 for a store.
- `dm_addr` output 32: word address, with `[1:0]` forced to 00.
- `dm_wstrb` output 4: byte lane enables, 0 for loads.
- `dm_wdata` output 32: store data replicated into the lanes.
- `dm_ready` input 1: memory completes the request this cycle.
- `dm_rdata` input 32: read word, valid when `dm_ready` is high.
- `load_data` output 32: extended load result.
- `load_valid` output 1: one-cycle pulse when `load_data` is updated.
- `stall` output 1: hold the pipeline.
- `misalign` output 1: one-cycle pulse for a misaligned access.

## Operation
- The FSM has three states: IDLE, ACCESS and RESP.
- IDLE: a supported load or store with `valid_MEM=1` is accepted this cycle.
  - Register opcode, funct3, `addr[1:0]`, `dm_addr`, strobes and lane data, then go to ACCESS.
  - Unsupported funct3 values (load 3/6/7, store 3-7) are a no-op: no request, no stall.
- ACCESS: `dm_req=1`.
  - `dm_addr`, `dm_we`, `dm_wstrb` and `dm_wdata` are held constant until `dm_ready`.
  - On `dm_ready`, capture `dm_rdata` if the access is a load, then go to RESP.
- RESP: go to IDLE next cycle. A new access is accepted no earlier than IDLE.
- Store lanes (`a` = `addr[1:0]`):
  - SB: `wstrb = 4'b0001 << a`, `wdata = {4{sd[7:0]}}`.
  - SH: `wstrb = 4'b0011 << {a[1],0}`, `wdata = {2{sd[15:0]}}`.
  - SW: `wstrb = 4'b1111`, `wdata = sd`.
- Load extract:
  - The byte or halfword is selected by the registered `a`.
  - LB and LH sign-extend bit 7 or bit 15.
  - LBU and LHU zero-extend.
  - LW passes the word through.
- `load_data` holds its value until the next load completes. Stores never change it.

## Timing
- Reset: state IDLE; `dm_req`, `dm_we`, `dm_wstrb`, `dm_addr`, `dm_wdata`, `load_data`, `load_valid`, `stall` and `misalign` are all 0.
- `stall` is combinational. It is 1 in the accept cycle T and in every ACCESS cycle, and 0 in RESP.
- `dm_req` first rises at T+1, and its outputs are registered.
- Minimum latency is 2 cycles: accept at T, `dm_ready` at T+1, `load_valid=1` at T+2.
- Each wait cycle without `dm_ready` adds one cycle.
- `load_valid` is high only in RESP of a load. The pipeline advances at the end of RESP.
- `dm_ready` is ignored outside ACCESS.
- If `rst_n=0` during ACCESS, `dm_req` drops at the next edge. The memory must tolerate an abandoned request; a late `dm_ready` is ignored.
- `valid_MEM` changes while `stall=1` are ignored, because the pipeline is held.

## Configuration
- `LSU_MISALIGN_TRAP_EN` defined:
  - A misaligned access is LH/LHU/SH with `addr[0]=1`, or LW/SW with `addr[1:0]!=0`.
  - A misaligned access issues no request, asserts `misalign` for one cycle in the accept cycle, holds `stall=0` and leaves `load_data` unchanged.
- `LSU_MISALIGN_TRAP_EN` undefined:
  - `misalign` is tied to 0.
  - For halfword accesses `addr[0]` is treated as 0; for word accesses `addr[1:0]` is treated as 00.
  - The access then proceeds normally.

## Test plan
- LW at 0x100, `dm_ready` at T+1 with rdata 0xDEADBEEF -> `dm_addr=0x100`, `wstrb=0`, `load_data=0xDEADBEEF`, `load_valid` pulse at T+2, `stall` high in T and T+1 only.
- LB/LBU at 0x203 with rdata 0x80FF7F01 -> LB gives 0xFFFFFF80, LBU gives 0x00000080; LH at 0x202 gives 0xFFFF80FF.
- SB at 0x301 with sd 0x123456AB -> `dm_addr=0x300`, `wstrb=0010`, `wdata=0xABABABAB`, `dm_we=1`. SH at 0x302 -> `wstrb=1100`, `wdata=0x56AB56AB`.
- LW with `dm_ready` delayed 3 cycles -> `dm_req` and `dm_addr` are stable throughout, `stall` is high for 4 cycles, then `load_valid` pulses.
- LW at 0x102 -> with the macro, `misalign` pulses, there is no `dm_req` and `stall=0`. Without the macro, `dm_addr=0x100` and the load completes.
- Reset asserted mid-ACCESS, then `dm_ready` arrives -> all outputs are 0, no `load_valid`, state IDLE.

Source files
------------

// File: rtl/lsu_mem.sv
// MEM-stage load/store unit: byte-strobed request/ready access to data memory, sign/zero-extended loads; LSU_MISALIGN_TRAP_EN traps misaligned accesses.
// Latency: accept at T, request from T+1, load_valid two cycles after accept plus one per cycle without dm_ready.
// Backpressure: stall is high in the accept cycle and while the request waits for dm_ready; no new access until IDLE.
module lsu_mem #(
   parameter int data_size = 32
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   valid_MEM,
   input  logic [6:0]             opcode_MEM,
   input  logic [2:0]             funct3_MEM,
   input  logic [data_size-1:0]   addr,
   input  logic [data_size-1:0]   store_data,
   output logic                   dm_req,
   output logic                   dm_we,
   output logic [data_size-1:0]   dm_addr,
   output logic [data_size/8-1:0] dm_wstrb,
   output logic [data_size-1:0]   dm_wdata,
   input  logic                   dm_ready,
   input  logic [data_size-1:0]   dm_rdata,
   output logic [data_size-1:0]   load_data,
   output logic                   load_valid,
   output logic                   stall,
   output logic                   misalign
);

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state_q, state_d;

   logic                   is_load, is_store, supported, is_half, is_word, accept;
   logic [1:0]             a_eff, a_q;
   logic [2:0]             f3_q;
   logic                   is_load_q;
   logic [data_size/8-1:0] strb_d;
   logic [data_size-1:0]   wdata_d, ext;
   logic [7:0]             byte_sel;
   logic [15:0]            half_sel;

   assign is_load   = (opcode_MEM == OP_LOAD);
   assign is_store  = (opcode_MEM == OP_STORE);
   assign supported = (is_load  && (funct3_MEM inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
                      (is_store && (funct3_MEM inside {3'd0, 3'd1, 3'd2}));
   assign is_half   = (funct3_MEM[1:0] == 2'b01);
   assign is_word   = (funct3_MEM[1:0] == 2'b10);

   // Low address bits below the access size are ignored, so lanes stay naturally aligned
   assign a_eff = is_word ? 2'b00 : (is_half ? {addr[1], 1'b0} : addr[1:0]);

   always_comb begin
      strb_d  = '0;
      wdata_d = '0;
      if (is_store) begin
         case (funct3_MEM[1:0])
            2'b00: begin
               strb_d  = 4'b0001 << a_eff;
               wdata_d = {(data_size/8){store_data[7:0]}};
            end
            2'b01: begin
               strb_d  = 4'b0011 << a_eff;
               wdata_d = {(data_size/16){store_data[15:0]}};
            end
            default: begin
               strb_d  = '1;
               wdata_d = store_data;
            end
         endcase
      end
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic mis_addr, mis_pulse;
   assign mis_addr = (is_half && addr[0]) || (is_word && (addr[1:0] != 2'b00));
   assign misalign = mis_pulse;
`else
   assign misalign = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      accept  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_pulse = 1'b0;
`endif
      case (state_q)
         IDLE: begin
            if (valid_MEM && supported) begin
`ifdef LSU_MISALIGN_TRAP_EN
               if (mis_addr) begin
                  mis_pulse = 1'b1;
               end else begin
                  accept  = 1'b1;
                  state_d = ACCESS;
               end
`else
               accept  = 1'b1;
               state_d = ACCESS;
`endif
            end
         end
         ACCESS:  if (dm_ready) state_d = RESP;
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (!rst_n) begin
         accept = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
         mis_pulse = 1'b0;
`endif
      end
   end

   assign stall = accept || (state_q == ACCESS);

   always_comb begin
      case (a_q)
         2'd0:    byte_sel = dm_rdata[7:0];
         2'd1:    byte_sel = dm_rdata[15:8];
         2'd2:    byte_sel = dm_rdata[23:16];
         default: byte_sel = dm_rdata[31:24];
      endcase
      half_sel = a_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
      case (f3_q)
         3'd0:    ext = {{(data_size-8){byte_sel[7]}}, byte_sel};
         3'd1:    ext = {{(data_size-16){half_sel[15]}}, half_sel};
         3'd4:    ext = {{(data_size-8){1'b0}}, byte_sel};
         3'd5:    ext = {{(data_size-16){1'b0}}, half_sel};
         default: ext = dm_rdata;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q    <= IDLE;
         dm_req     <= 1'b0;
         dm_we      <= 1'b0;
         dm_addr    <= '0;
         dm_wstrb   <= '0;
         dm_wdata   <= '0;
         load_data  <= '0;
         load_valid <= 1'b0;
         is_load_q  <= 1'b0;
         f3_q       <= 3'd0;
         a_q        <= 2'd0;
      end else begin
         state_q    <= state_d;
         load_valid <= 1'b0;
         if (accept) begin
            dm_req    <= 1'b1;
            dm_we     <= is_store;
            dm_addr   <= {addr[data_size-1:2], 2'b00};
            dm_wstrb  <= strb_d;
            dm_wdata  <= wdata_d;
            is_load_q <= is_load;
            f3_q      <= funct3_MEM;
            a_q       <= a_eff;
         end else if (state_q == ACCESS && dm_ready) begin
            dm_req <= 1'b0;
            if (is_load_q) begin
               load_data  <= ext;
               load_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: loads, stores, wait states, unsupported ops, misalignment and mid-access reset.
module tb_lsu_mem;

   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        valid_MEM;
   logic [6:0]  opcode_MEM;
   logic [2:0]  funct3_MEM;
   logic [31:0] addr, store_data;
   logic        dm_req, dm_we;
   logic [31:0] dm_addr, dm_wdata;
   logic [3:0]  dm_wstrb;
   logic        dm_ready;
   logic [31:0] dm_rdata, load_data;
   logic        load_valid, stall, misalign;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   lsu_mem #(.data_size(32)) dut (
      .clk(clk), .rst_n(rst_n), .valid_MEM(valid_MEM), .opcode_MEM(opcode_MEM),
      .funct3_MEM(funct3_MEM), .addr(addr), .store_data(store_data),
      .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wstrb(dm_wstrb),
      .dm_wdata(dm_wdata), .dm_ready(dm_ready), .dm_rdata(dm_rdata),
      .load_data(load_data), .load_valid(load_valid), .stall(stall), .misalign(misalign)
   );

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      assert (act === exp) else begin
         n_err++;
         $error("FAIL %s: observed %h expected %h", tag, act, exp);
      end
   endtask

   // Issue one access; dm_ready arrives after 'waits' extra ACCESS cycles.
   task automatic txn(input string tag, input logic [6:0] op, input logic [2:0] f3,
                      input logic [31:0] a, input logic [31:0] sd, input logic [31:0] rd,
                      input int waits, input logic [31:0] exp_addr, input logic [3:0] exp_strb,
                      input logic [31:0] exp_wdata, input logic [31:0] exp_ld);
      int stall_cnt;
      logic is_ld;
      is_ld = (op == OP_LOAD);
      stall_cnt = 0;
      @(posedge clk); #1;
      valid_MEM = 1'b1; opcode_MEM = op; funct3_MEM = f3; addr = a; store_data = sd;
      @(negedge clk);
      chk({tag, " accept stall"}, {31'b0, stall}, 32'd1);
      chk({tag, " accept req"}, {31'b0, dm_req}, 32'd0);
      stall_cnt += int'(stall);
      @(posedge clk); #1;
      valid_MEM = 1'b0; opcode_MEM = 7'd0; addr = 32'hFFFF_FFFF; store_data = 32'hFFFF_FFFF;
      for (int i = 0; i <= waits; i++) begin
         if (i == waits) begin
            dm_ready = 1'b1; dm_rdata = rd;
         end
         @(negedge clk);
         chk({tag, " req"}, {31'b0, dm_req}, 32'd1);
         chk({tag, " addr"}, dm_addr, exp_addr);
         chk({tag, " we"}, {31'b0, dm_we}, {31'b0, ~is_ld});
         chk({tag, " wstrb"}, {28'b0, dm_wstrb}, {28'b0, exp_strb});
         if (!is_ld) chk({tag, " wdata"}, dm_wdata, exp_wdata);
         stall_cnt += int'(stall);
         @(posedge clk); #1;
      end
      dm_ready = 1'b0; dm_rdata = 32'h0;
      @(negedge clk);
      chk({tag, " resp stall"}, {31'b0, stall}, 32'd0);
      chk({tag, " resp req"}, {31'b0, dm_req}, 32'd0);
      chk({tag, " resp load_valid"}, {31'b0, load_valid}, {31'b0, is_ld});
      chk({tag, " load_data"}, load_data, exp_ld);
      chk({tag, " stall cycles"}, stall_cnt, waits + 2);
      @(posedge clk); #1;
      @(negedge clk);
      chk({tag, " load_valid drop"}, {31'b0, load_valid}, 32'd0);
      chk({tag, " load_data held"}, load_data, exp_ld);
   endtask

   initial begin
      rst_n = 1'b0; valid_MEM = 1'b0; opcode_MEM = 7'd0; funct3_MEM = 3'd0;
      addr = 32'd0; store_data = 32'd0; dm_ready = 1'b0; dm_rdata = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("rst req", {31'b0, dm_req}, 32'd0);
      chk("rst we", {31'b0, dm_we}, 32'd0);
      chk("rst wstrb", {28'b0, dm_wstrb}, 32'd0);
      chk("rst addr", dm_addr, 32'd0);
      chk("rst wdata", dm_wdata, 32'd0);
      chk("rst load_data", load_data, 32'd0);
      chk("rst load_valid", {31'b0, load_valid}, 32'd0);
      chk("rst stall", {31'b0, stall}, 32'd0);
      chk("rst misalign", {31'b0, misalign}, 32'd0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      txn("LW",  OP_LOAD, 3'd2, 32'h100, 32'h0, 32'hDEADBEEF, 0, 32'h100, 4'b0000, 32'h0, 32'hDEADBEEF);
      txn("LB",  OP_LOAD, 3'd0, 32'h203, 32'h0, 32'h80FF7F01, 0, 32'h200, 4'b0000, 32'h0, 32'hFFFFFF80);
      txn("LBU", OP_LOAD, 3'd4, 32'h203, 32'h0, 32'h80FF7F01, 0, 32'h200, 4'b0000, 32'h0, 32'h00000080);
      txn("LH",  OP_LOAD, 3'd1, 32'h202, 32'h0, 32'h80FF7F01, 0, 32'h200, 4'b0000, 32'h0, 32'hFFFF80FF);
      txn("LHU", OP_LOAD, 3'd5, 32'h200, 32'h0, 32'h80FF7F01, 0, 32'h200, 4'b0000, 32'h0, 32'h00007F01);
      txn("SB",  OP_STORE, 3'd0, 32'h301, 32'h123456AB, 32'h99999999, 0, 32'h300, 4'b0010, 32'hABABABAB, 32'h00007F01);
      txn("SH",  OP_STORE, 3'd1, 32'h302, 32'h123456AB, 32'h99999999, 0, 32'h300, 4'b1100, 32'h56AB56AB, 32'h00007F01);
      txn("SW",  OP_STORE, 3'd2, 32'h304, 32'h12345678, 32'h99999999, 1, 32'h304, 4'b1111, 32'h12345678, 32'h00007F01);
      txn("LW wait", OP_LOAD, 3'd2, 32'h100, 32'h0, 32'hCAFEF00D, 2, 32'h100, 4'b0000, 32'h0, 32'hCAFEF00D);

      // Unsupported load size is a no-op
      @(posedge clk); #1;
      valid_MEM = 1'b1; opcode_MEM = OP_LOAD; funct3_MEM = 3'd3; addr = 32'h400;
      @(negedge clk);
      chk("bad f3 stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      valid_MEM = 1'b0; opcode_MEM = 7'd0;
      @(negedge clk);
      chk("bad f3 req", {31'b0, dm_req}, 32'd0);

`ifdef LSU_MISALIGN_TRAP_EN
      @(posedge clk); #1;
      valid_MEM = 1'b1; opcode_MEM = OP_LOAD; funct3_MEM = 3'd2; addr = 32'h102;
      @(negedge clk);
      chk("mis pulse", {31'b0, misalign}, 32'd1);
      chk("mis stall", {31'b0, stall}, 32'd0);
      @(posedge clk); #1;
      valid_MEM = 1'b0; opcode_MEM = 7'd0;
      @(negedge clk);
      chk("mis req", {31'b0, dm_req}, 32'd0);
      chk("mis drop", {31'b0, misalign}, 32'd0);
      chk("mis load_data", load_data, 32'hCAFEF00D);
`else
      txn("LW mis", OP_LOAD, 3'd2, 32'h102, 32'h0, 32'h11223344, 0, 32'h100, 4'b0000, 32'h0, 32'h11223344);
      chk("mis tied", {31'b0, misalign}, 32'd0);
`endif

      // Reset while ACCESS waits, then a late dm_ready
      @(posedge clk); #1;
      valid_MEM = 1'b1; opcode_MEM = OP_LOAD; funct3_MEM = 3'd2; addr = 32'h404;
      @(posedge clk); #1;
      valid_MEM = 1'b0; opcode_MEM = 7'd0;
      rst_n = 1'b0;
      @(negedge clk);
      chk("mid rst req before edge", {31'b0, dm_req}, 32'd1);
      @(posedge clk); #1;
      rst_n = 1'b1; dm_ready = 1'b1; dm_rdata = 32'h55555555;
      @(negedge clk);
      chk("mid rst req", {31'b0, dm_req}, 32'd0);
      chk("mid rst addr", dm_addr, 32'd0);
      chk("mid rst stall", {31'b0, stall}, 32'd0);
      chk("mid rst load_data", load_data, 32'd0);
      @(posedge clk); #1;
      dm_ready = 1'b0; dm_rdata = 32'h0;
      @(negedge clk);
      chk("mid rst late ready", {31'b0, load_valid}, 32'd0);
      chk("mid rst late data", load_data, 32'd0);

      txn("LW post rst", OP_LOAD, 3'd2, 32'h500, 32'h0, 32'h0A0B0C0D, 0, 32'h500, 4'b0000, 32'h0, 32'h0A0B0C0D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
